// File: rtl/ball_ctrl_if.sv
// ball_ctrl_if: playfield bus between the top level and the ball engine.
//
// Carries the serve request, the VGA scan position, the paddle geometry
// and the ball engine's outputs (position, pixel colour, lives, status).
//
//   launch         serve request (level)
//   x, y           current scan coordinates
//   active_pixels  scan is inside the visible region
//   paddle_*       paddle left/top edge, width and height
//   ball_x/ball_y  ball top-left corner
//   vga_color      ball pixel colour for the colour mux
//   lives          remaining lives
//   ball_lost      one-cycle pulse when the ball leaves the bottom
//   game_over      no lives left
//
// master: the playfield top level (drives inputs, reads results)
// slave : the ball engine
interface ball_ctrl_if;
  logic        launch;
  logic [9:0]  x;
  logic [9:0]  y;
  logic        active_pixels;
  logic [9:0]  paddle_x;
  logic [9:0]  paddle_y;
  logic [9:0]  paddle_width;
  logic [9:0]  paddle_height;
  logic [9:0]  ball_x;
  logic [9:0]  ball_y;
  logic [23:0] vga_color;
  logic [1:0]  lives;
  logic        ball_lost;
  logic        game_over;

  modport master (
    output launch, x, y, active_pixels,
    output paddle_x, paddle_y, paddle_width, paddle_height,
    input  ball_x, ball_y, vga_color, lives, ball_lost, game_over
  );

  modport slave (
    input  launch, x, y, active_pixels,
    input  paddle_x, paddle_y, paddle_width, paddle_height,
    output ball_x, ball_y, vga_color, lives, ball_lost, game_over
  );
endinterface

// File: rtl/ball_ctrl.sv
// ball_ctrl: ball engine for the brick-breaker playfield.
//
// Parks the ball on the paddle until a serve, then moves it one pixel per
// move tick, bouncing off the left/right/top walls and the paddle top.
// Leaving through the bottom costs a life; with no lives left the game
// stops until reset.
//
// Ports:
//   clk  system clock
//   rst  asynchronous active-high reset
//   bus  ball_ctrl_if.slave (launch, scan x/y, active_pixels, paddle
//        geometry in; ball_x/ball_y, vga_color, lives, ball_lost,
//        game_over out)
//
// state | meaning
// ------+--------------------------------------------------------------
// SERVE | ball rides on the paddle centre, waiting for launch
// MOVE  | ball in flight, stepped on each move tick
// LOST  | single cycle: ball left the bottom, a life is taken
// OVER  | no lives left, ball hidden, held until reset
module ball_ctrl #(
  parameter int BALL_SIZE = 8,
  parameter int SCREEN_W  = 640,
  parameter int SCREEN_H  = 480,
  parameter int TICK_DIV  = 208333,
  parameter int START_X   = 316,
  parameter int START_Y   = 412,
  parameter int LIVES     = 3
) (
  input  logic       clk,
  input  logic       rst,
  ball_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    S_SERVE = 2'd0,
    S_MOVE  = 2'd1,
    S_LOST  = 2'd2,
    S_OVER  = 2'd3
  } state_t;

  localparam int CNT_W = (TICK_DIV > 0) ? $clog2(TICK_DIV + 1) : 1;
  localparam logic [CNT_W-1:0] TICK_TC = CNT_W'(TICK_DIV);
  localparam logic [10:0] SIZE11 = 11'(BALL_SIZE);
  localparam logic [10:0] HALF11 = 11'(BALL_SIZE / 2);
  localparam logic [10:0] SCR_W11 = 11'(SCREEN_W);
  localparam logic [10:0] SCR_H11 = 11'(SCREEN_H);
  localparam logic [9:0] SIZE10 = 10'(BALL_SIZE);

  state_t           state_q, state_d;
  logic [9:0]       ball_x_q, ball_x_d;
  logic [9:0]       ball_y_q, ball_y_d;
  logic             dir_x_pos_q, dir_x_pos_d;   // 1: moving right
  logic             dir_y_down_q, dir_y_down_d; // 1: moving down
  logic [1:0]       lives_q, lives_d;
  logic [CNT_W-1:0] tick_cnt_q, tick_cnt_d;
  logic             tick;

  // 11-bit edge sums so a ball or paddle near 1023 does not wrap.
  logic [10:0] ball_right;
  logic [10:0] ball_bottom;
  logic [10:0] paddle_right;
  logic [10:0] paddle_centre;
  logic [9:0]  serve_x;
  logic [9:0]  serve_y;

  logic hit_left, hit_right, hit_top, hit_paddle, hit_bottom;
  logic in_x, in_y;

  // Paddle height plays no part in the bounce; kept on the bus for later use.
  logic unused_paddle_height;
  assign unused_paddle_height = ^bus.paddle_height;

  assign tick = (tick_cnt_q == TICK_TC);

  assign ball_right    = {1'b0, ball_x_q} + SIZE11;
  assign ball_bottom   = {1'b0, ball_y_q} + SIZE11;
  assign paddle_right  = {1'b0, bus.paddle_x} + {1'b0, bus.paddle_width};
  assign paddle_centre = {1'b0, bus.paddle_x} + {2'b00, bus.paddle_width[9:1]};

  // Centre the ball over the paddle; a paddle hugging the left edge would
  // put the ball left of column 0, so pin it there instead.
  assign serve_x = (paddle_centre < HALF11) ? 10'd0 : 10'(paddle_centre - HALF11);
  assign serve_y = bus.paddle_y - SIZE10;

  assign hit_left   = !dir_x_pos_q && (ball_x_q == 10'd0);
  assign hit_right  = dir_x_pos_q && (ball_right >= SCR_W11);
  assign hit_top    = !dir_y_down_q && (ball_y_q == 10'd0);
  assign hit_paddle = dir_y_down_q
                      && (ball_bottom == {1'b0, bus.paddle_y})
                      && (ball_right > {1'b0, bus.paddle_x})
                      && ({1'b0, ball_x_q} < paddle_right);
  // A paddle save wins over the bottom exit.
  assign hit_bottom = dir_y_down_q && (ball_bottom >= SCR_H11) && !hit_paddle;

  always_comb begin
    state_d      = state_q;
    ball_x_d     = ball_x_q;
    ball_y_d     = ball_y_q;
    dir_x_pos_d  = dir_x_pos_q;
    dir_y_down_d = dir_y_down_q;
    lives_d      = lives_q;
    tick_cnt_d   = tick ? '0 : tick_cnt_q + CNT_W'(1);

    case (state_q)
      S_SERVE: begin
        ball_x_d = serve_x;
        ball_y_d = serve_y;
        if (bus.launch) begin
          state_d      = S_MOVE;
          dir_x_pos_d  = 1'b1;
          dir_y_down_d = 1'b0;
        end
      end

      S_MOVE: begin
        if (tick) begin
          if (hit_bottom) begin
            state_d = S_LOST;
          end else begin
            // Flip first, then step in the new direction; corner hits flip both.
            dir_x_pos_d  = dir_x_pos_q ^ (hit_left | hit_right);
            dir_y_down_d = dir_y_down_q ^ (hit_top | hit_paddle);
            ball_x_d     = dir_x_pos_d ? ball_x_q + 10'd1 : ball_x_q - 10'd1;
            ball_y_d     = dir_y_down_d ? ball_y_q + 10'd1 : ball_y_q - 10'd1;
          end
        end
      end

      S_LOST: begin
        lives_d = lives_q - 2'd1;
        if (lives_q == 2'd1) begin
          state_d = S_OVER;
        end else begin
          state_d      = S_SERVE;
          dir_x_pos_d  = 1'b1;
          dir_y_down_d = 1'b0;
        end
      end

      S_OVER: begin
        lives_d = 2'd0;
      end

      default: begin
        state_d = S_SERVE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_SERVE;
      ball_x_q     <= 10'(START_X);
      ball_y_q     <= 10'(START_Y);
      dir_x_pos_q  <= 1'b1;
      dir_y_down_q <= 1'b0;
      lives_q      <= 2'(LIVES);
      tick_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      ball_x_q     <= ball_x_d;
      ball_y_q     <= ball_y_d;
      dir_x_pos_q  <= dir_x_pos_d;
      dir_y_down_q <= dir_y_down_d;
      lives_q      <= lives_d;
      tick_cnt_q   <= tick_cnt_d;
    end
  end

  // Half-open ball box: [ball_x, ball_x+BALL_SIZE) x [ball_y, ball_y+BALL_SIZE).
  assign in_x = (bus.x >= ball_x_q) && ({1'b0, bus.x} < ball_right);
  assign in_y = (bus.y >= ball_y_q) && ({1'b0, bus.y} < ball_bottom);

  assign bus.vga_color = (bus.active_pixels && in_x && in_y && (state_q != S_OVER))
                         ? 24'hFFFF00 : 24'h000000;
  assign bus.ball_x    = ball_x_q;
  assign bus.ball_y    = ball_y_q;
  assign bus.lives     = lives_q;
  assign bus.ball_lost = (state_q == S_LOST);
  assign bus.game_over = (state_q == S_OVER);

endmodule

// File: tb/tb_ball_ctrl.sv
`timescale 1ns/1ps
module tb_ball_ctrl;
  logic clk = 1'b0;
  logic rst;

  ball_ctrl_if bus();

  ball_ctrl #(.TICK_DIV(3)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [9:0]  bx;
    logic [9:0]  by;
    logic [1:0]  lv;
    logic        go;
    logic        lost;
    logic [23:0] col;
  } exp_t;

  exp_t       exp_q[$];
  logic [1:0] lost_q[$];
  int checks = 0;
  int errors = 0;

  exp_t       mon_e;
  logic [1:0] mon_lv;

  // Monitor: compares snapshot expectations and every ball_lost pulse.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      checks++;
      if (bus.ball_x !== mon_e.bx || bus.ball_y !== mon_e.by || bus.lives !== mon_e.lv ||
          bus.game_over !== mon_e.go || bus.ball_lost !== mon_e.lost ||
          bus.vga_color !== mon_e.col) begin
        errors++;
        $display("FAIL %s: got x=%0d y=%0d lives=%0d over=%b lost=%b color=%06h; want x=%0d y=%0d lives=%0d over=%b lost=%b color=%06h",
                 mon_e.name, bus.ball_x, bus.ball_y, bus.lives, bus.game_over, bus.ball_lost,
                 bus.vga_color, mon_e.bx, mon_e.by, mon_e.lv, mon_e.go, mon_e.lost, mon_e.col);
      end
    end
    if (bus.ball_lost === 1'b1) begin
      checks++;
      if (lost_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_ball_lost: got pulse with lives=%0d, want no pulse", bus.lives);
      end else begin
        mon_lv = lost_q.pop_front();
        if (bus.lives !== mon_lv) begin
          errors++;
          $display("FAIL ball_lost_lives: got lives=%0d during pulse, want %0d", bus.lives, mon_lv);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [9:0] bx, input logic [9:0] by,
                     input logic [1:0] lv, input logic go, input logic lost,
                     input logic [23:0] col);
    exp_t e;
    e.name = name; e.bx = bx; e.by = by; e.lv = lv; e.go = go; e.lost = lost; e.col = col;
    exp_q.push_back(e);
    @(negedge clk);
    #1;
  endtask

  task automatic wait_pos(input string name, input logic [9:0] bx, input logic [9:0] by,
                          input int budget);
    int n = 0;
    while (!(bus.ball_x == bx && bus.ball_y == by) && n < budget) begin
      step();
      n++;
    end
    checks++;
    if (!(bus.ball_x == bx && bus.ball_y == by)) begin
      errors++;
      $display("FAIL %s timeout: at x=%0d y=%0d, want x=%0d y=%0d", name, bus.ball_x, bus.ball_y, bx, by);
    end
  endtask

  task automatic wait_change(input string name, input int budget);
    logic [9:0] ox, oy;
    int n = 0;
    ox = bus.ball_x;
    oy = bus.ball_y;
    while (bus.ball_x == ox && bus.ball_y == oy && n < budget) begin
      step();
      n++;
    end
    checks++;
    if (bus.ball_x == ox && bus.ball_y == oy) begin
      errors++;
      $display("FAIL %s timeout: ball stuck at x=%0d y=%0d, want a step", name, ox, oy);
    end
  endtask

  task automatic wait_lost(input string name, input int budget);
    int n = 0;
    while (bus.ball_lost !== 1'b1 && n < budget) begin
      step();
      n++;
    end
    checks++;
    if (bus.ball_lost !== 1'b1) begin
      errors++;
      $display("FAIL %s timeout: got no ball_lost, at x=%0d y=%0d, want pulse", name, bus.ball_x, bus.ball_y);
    end
  endtask

  task automatic set_paddle(input logic [9:0] px, input logic [9:0] pw);
    bus.paddle_x = px;
    bus.paddle_width = pw;
  endtask

  // From a serve at (200,432): up to the (632,0) corner, back down past a
  // paddle moved to (0,4), out through the bottom at (160,472).
  task automatic lose_one(input string name, input logic [1:0] lv_before, input logic last);
    bus.launch = 1'b1;
    step();
    bus.launch = 1'b0;
    set_paddle(10'd0, 10'd4);
    lost_q.push_back(lv_before);
    wait_lost(name, 5000);
    set_paddle(10'd154, 10'd100);
    step();
    chk({name, "_held"}, 10'd160, 10'd472, lv_before - 2'd1, last, 1'b0, 24'h0);
    if (!last) begin
      step();
      chk({name, "_reserve"}, 10'd200, 10'd432, lv_before - 2'd1, 1'b0, 1'b0, 24'h0);
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.launch = 1'b0;
    bus.x = 10'd316;
    bus.y = 10'd412;
    bus.active_pixels = 1'b1;
    bus.paddle_x = 10'd200;
    bus.paddle_y = 10'd440;
    bus.paddle_width = 10'd100;
    bus.paddle_height = 10'd16;

    // Reset state, ball drawn at the start position.
    step();
    chk("reset_state", 10'd316, 10'd412, 2'd3, 1'b0, 1'b0, 24'hFFFF00);
    bus.active_pixels = 1'b0;
    @(posedge clk); #1; rst = 1'b0;

    // Serve tracking and clamp.
    step();
    chk("serve_pos", 10'd246, 10'd432, 2'd3, 1'b0, 1'b0, 24'h0);
    set_paddle(10'd0, 10'd4);
    step();
    chk("serve_clamp", 10'd0, 10'd432, 2'd3, 1'b0, 1'b0, 24'h0);
    set_paddle(10'd200, 10'd100);
    step();
    chk("serve_back", 10'd246, 10'd432, 2'd3, 1'b0, 1'b0, 24'h0);

    // Pixel box at (246,432).
    bus.active_pixels = 1'b1;
    bus.x = 10'd246; bus.y = 10'd432;
    chk("pix_top_left", 10'd246, 10'd432, 2'd3, 1'b0, 1'b0, 24'hFFFF00);
    bus.x = 10'd253; bus.y = 10'd439;
    chk("pix_bottom_right", 10'd246, 10'd432, 2'd3, 1'b0, 1'b0, 24'hFFFF00);
    bus.x = 10'd254; bus.y = 10'd435;
    chk("pix_x_excl", 10'd246, 10'd432, 2'd3, 1'b0, 1'b0, 24'h0);
    bus.x = 10'd250; bus.y = 10'd440;
    chk("pix_y_excl", 10'd246, 10'd432, 2'd3, 1'b0, 1'b0, 24'h0);
    bus.x = 10'd245; bus.y = 10'd435;
    chk("pix_left_out", 10'd246, 10'd432, 2'd3, 1'b0, 1'b0, 24'h0);
    bus.x = 10'd250; bus.y = 10'd435; bus.active_pixels = 1'b0;
    chk("pix_blanked", 10'd246, 10'd432, 2'd3, 1'b0, 1'b0, 24'h0);

    // Long flight: corner, paddle bounce, left/top/right walls, paddle miss.
    set_paddle(10'd154, 10'd100);
    step();
    chk("serve_200", 10'd200, 10'd432, 2'd3, 1'b0, 1'b0, 24'h0);
    bus.launch = 1'b1;
    step();
    wait_change("first_step", 8);
    chk("move_step1", 10'd201, 10'd431, 2'd3, 1'b0, 1'b0, 24'h0);
    for (int i = 0; i < 3; i++) begin
      repeat (4) @(posedge clk);
      #1;
      chk("move_every4", 10'(202 + i), 10'(430 - i), 2'd3, 1'b0, 1'b0, 24'h0);
    end
    bus.launch = 1'b0;
    wait_pos("reach_corner", 10'd632, 10'd0, 2500);
    chk("at_corner", 10'd632, 10'd0, 2'd3, 1'b0, 1'b0, 24'h0);
    wait_change("corner_step", 8);
    chk("corner_flip", 10'd631, 10'd1, 2'd3, 1'b0, 1'b0, 24'h0);
    repeat (4) @(posedge clk);
    #1;
    chk("corner_dir", 10'd630, 10'd2, 2'd3, 1'b0, 1'b0, 24'h0);
    set_paddle(10'd200, 10'd100);
    wait_pos("reach_paddle", 10'd200, 10'd432, 2500);
    wait_change("paddle_step", 8);
    chk("paddle_bounce", 10'd199, 10'd431, 2'd3, 1'b0, 1'b0, 24'h0);
    wait_pos("reach_left", 10'd0, 10'd232, 2500);
    wait_change("left_step", 8);
    chk("left_wall", 10'd1, 10'd231, 2'd3, 1'b0, 1'b0, 24'h0);
    wait_pos("reach_top", 10'd232, 10'd0, 2500);
    wait_change("top_step", 8);
    chk("top_wall", 10'd233, 10'd1, 2'd3, 1'b0, 1'b0, 24'h0);
    set_paddle(10'd608, 10'd100);
    wait_pos("reach_right", 10'd632, 10'd400, 2500);
    wait_change("right_step", 8);
    chk("right_wall", 10'd631, 10'd401, 2'd3, 1'b0, 1'b0, 24'h0);
    wait_pos("reach_paddle_edge", 10'd600, 10'd432, 2500);
    wait_change("miss_step", 8);
    chk("paddle_edge_miss", 10'd599, 10'd433, 2'd3, 1'b0, 1'b0, 24'h0);
    lost_q.push_back(2'd3);
    wait_lost("lost1", 400);
    set_paddle(10'd154, 10'd100);
    step();
    chk("lost1_held", 10'd560, 10'd472, 2'd2, 1'b0, 1'b0, 24'h0);
    step();
    chk("lost1_reserve", 10'd200, 10'd432, 2'd2, 1'b0, 1'b0, 24'h0);

    // Remaining two lives.
    lose_one("lost2", 2'd2, 1'b0);
    lose_one("lost3", 2'd1, 1'b1);

    bus.x = 10'd160; bus.y = 10'd472; bus.active_pixels = 1'b1;
    chk("over_not_drawn", 10'd160, 10'd472, 2'd0, 1'b1, 1'b0, 24'h0);
    bus.launch = 1'b1;
    repeat (8) step();
    chk("over_launch_ignored", 10'd160, 10'd472, 2'd0, 1'b1, 1'b0, 24'h0);
    bus.launch = 1'b0;

    // Reset out of OVER, mid-cycle.
    @(posedge clk); #3; rst = 1'b1; #1;
    chk("rst_in_over", 10'd316, 10'd412, 2'd3, 1'b0, 1'b0, 24'h0);

    // Tick counter restarts from zero: launch on the first edge, first step
    // on the fourth.
    bus.active_pixels = 1'b0;
    set_paddle(10'd200, 10'd100);
    bus.launch = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    step();
    chk("relaunch_p1", 10'd246, 10'd432, 2'd3, 1'b0, 1'b0, 24'h0);
    repeat (2) @(posedge clk);
    #1;
    chk("relaunch_p3", 10'd246, 10'd432, 2'd3, 1'b0, 1'b0, 24'h0);
    step();
    chk("relaunch_p4", 10'd247, 10'd431, 2'd3, 1'b0, 1'b0, 24'h0);
    bus.launch = 1'b0;

    // Reset mid-MOVE.
    repeat (2) step();
    bus.x = 10'd316; bus.y = 10'd412; bus.active_pixels = 1'b1;
    @(posedge clk); #3; rst = 1'b1; #1;
    chk("rst_mid_move", 10'd316, 10'd412, 2'd3, 1'b0, 1'b0, 24'hFFFF00);
    step();
    rst = 1'b0;

    checks++;
    if (exp_q.size() != 0 || lost_q.size() != 0) begin
      errors++;
      $display("FAIL queues_drained: got %0d snapshots and %0d losses pending, want 0 and 0",
               exp_q.size(), lost_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/ball_ctrl.md
Name: ball_ctrl

Overview:
Ball engine for the brick-breaker playfield. It consumes the paddle geometry bus (paddle_x/y/width/height) and the pixel scan coordinates from the VGA timing block. It moves the ball on a divided tick, bounces it off the walls and the paddle, and tracks lives. It drives the ball's pixel colour for the top-level colour mux and exports ball position for the brick collision logic.

Parameters:
BALL_SIZE, 8, ball edge length in pixels (square)
SCREEN_W, 640, visible width
SCREEN_H, 480, visible height
TICK_DIV, 208333, move tick fires once every TICK_DIV+1 clk cycles
START_X, 316, ball_x reset value
START_Y, 412, ball_y reset value
LIVES, 3, lives loaded at reset (1..3)

Ports:
clk  in  1  system clock (50 MHz)
rst  in  1  asynchronous, active-high reset
launch  in  1  serve request, sampled each clk; active-high level
x  in  10  current scan x
y  in  10  current scan y
active_pixels  in  1  scan is in the visible region
paddle_x  in  10  paddle left edge
paddle_y  in  10  paddle top edge
paddle_width  in  10  paddle width
paddle_height  in  10  paddle height (unused for bounce; reserved)
ball_x  out  10  ball left edge, registered
ball_y  out  10  ball top edge, registered
vga_color  out  24  ball pixel colour, combinational
lives  out  2  remaining lives
ball_lost  out  1  one-cycle pulse when the ball exits the bottom
game_over  out  1  high in OVER state

Behaviour:
- Reset (async, rst=1): state=SERVE, ball_x=START_X, ball_y=START_Y, dir_x=+1, dir_y=-1, lives=LIVES, ball_lost=0, game_over=0, tick counter=0.
- Tick counter: free-running in all states. tick=1 for one cycle when count==TICK_DIV, then count returns to 0.
- Arithmetic: all edge sums (x+BALL_SIZE, paddle_x+paddle_width) use 11-bit intermediates, so there is no wrap at 1023.
- FSM states: SERVE, MOVE, LOST, OVER.
- SERVE, every clk (tick not required):
  - ball_x <= paddle_x + paddle_width/2 - BALL_SIZE/2, clamped to 0 if the result is negative.
  - ball_y <= paddle_y - BALL_SIZE.
  - If launch=1: go to MOVE with dir_x=+1, dir_y=-1.
- MOVE, on tick only:
  - First evaluate collisions on the current position and flip direction.
  - Then step ball_x and ball_y by 1 in the (possibly new) direction.
  - Left: dir_x=-1 and ball_x==0 -> dir_x=+1.
  - Right: dir_x=+1 and ball_x+BALL_SIZE>=SCREEN_W -> dir_x=-1.
  - Top: dir_y=-1 and ball_y==0 -> dir_y=+1.
  - Paddle: dir_y=+1, ball_y+BALL_SIZE==paddle_y, ball_x+BALL_SIZE>paddle_x and ball_x<paddle_x+paddle_width -> dir_y=-1.
  - Bottom: dir_y=+1 and ball_y+BALL_SIZE>=SCREEN_H -> go to LOST; position is held, no step.
  - Simultaneous x and y hits (corners) apply both flips on the same tick.
  - Paddle hit takes priority over bottom.
  - launch is ignored in MOVE, LOST and OVER.
- LOST (exactly one cycle): ball_lost=1 and lives decrements.
  - If lives was 1: go to OVER.
  - Otherwise: go to SERVE with dir reset to (+1,-1).
- OVER: game_over=1, ball is not drawn, lives=0. Held until rst.
- vga_color:
  - 0 when active_pixels=0.
  - 24'hFFFF00 when x in [ball_x, ball_x+BALL_SIZE) and y in [ball_y, ball_y+BALL_SIZE) and state!=OVER.
  - 0 otherwise.
- Reset asserted mid-MOVE or in OVER returns immediately to the reset values; no pending tick survives.

Test Plan:
1. TICK_DIV=3, rst pulse, paddle_x=200, width=100, paddle_y=440 -> after 1 clk ball_x=246, ball_y=432, state SERVE. Then paddle_x=0, width=4 -> ball_x=0 (clamp).
2. Serve at ball_x=246,y=432, launch=1 for 1 clk -> MOVE; every 4 clks ball_x+1, ball_y-1; launch held during MOVE has no effect.
3. Force ball to ball_x=632, ball_y=0, dir (+1,-1), on tick -> both flips; next position (631,1), dir (-1,+1).
4. Ball descending with ball_y+8==440, ball_x=290, paddle_x=200,width=100 -> dir_y=-1 on that tick, ball_y 431. Repeat with ball_x=300 (misses the paddle) -> continues down.
5. Ball reaches ball_y=472 descending -> ball_lost one-cycle pulse, lives 3->2, SERVE. Repeat twice -> lives 0, game_over=1, vga_color=0 at the ball location, launch ignored.
6. rst asserted asynchronously mid-tick in MOVE -> outputs return to the reset values within the same cycle (START_X/START_Y, lives=3, game_over=0). Pixel checks: active_pixels=0 gives 0 inside the ball; x=ball_x+8 gives 0 (exclusive edge).
